// File: rtl/serpent_stream_ctrl.sv
// rtl/serpent_stream_ctrl.sv - block sequencer for the external Serpent cipher cores
//
// Purpose:
//   Accepts DATA_W blocks on a start-pulse/ready handshake, registers each block
//   into the fixed-latency encrypt/decrypt datapath, captures the result after
//   the latency of the selected direction and presents it with a one-cycle
//   valid pulse. After reset or i_key_load no block is accepted until the key
//   schedule has had KEY_LAT cycles to settle. A key change aborts any block
//   in flight.
//   Optional CBC chaining is compiled in when the macro SERPENT_CBC_EN is
//   defined; otherwise the block runs in plain ECB mode.
//
// Ports:
//   i_clk, i_resetn   clock, asynchronous active-low reset
//   i_dir             1 = encrypt, 0 = decrypt (sampled on accept)
//   i_key_load        key changed: restart settle, abort block in flight
//   i_new_block       start pulse, accepted only while o_ready=1
//   i_data            input block
//   i_iv_load, i_iv   chaining register load (CBC build only)
//   o_core_data       registered block feeding both cipher cores
//   i_enc_data        encryption core result
//   i_dec_data        decryption core result
//   o_ready           idle and accepting a block
//   o_valid           one-cycle pulse: o_output holds a new result
//   o_output          registered result, held until the next capture
//   o_overrun         one-cycle pulse: i_new_block was dropped
module serpent_stream_ctrl #(
  parameter int DATA_W  = 128,
  parameter int ENC_LAT = 32,
  parameter int DEC_LAT = 64,
  parameter int KEY_LAT = 33,
  parameter int CNT_W   = 7
) (
  input  logic              i_clk,
  input  logic              i_resetn,
  input  logic              i_dir,
  input  logic              i_key_load,
  input  logic              i_new_block,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_iv_load,
  input  logic [DATA_W-1:0] i_iv,
  output logic [DATA_W-1:0] o_core_data,
  input  logic [DATA_W-1:0] i_enc_data,
  input  logic [DATA_W-1:0] i_dec_data,
  output logic              o_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_output,
  output logic              o_overrun
);

  typedef enum logic [1:0] {
    S_KEY_WAIT = 2'd0,
    S_IDLE     = 2'd1,
    S_BUSY     = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] ENC_LAT_C = CNT_W'(ENC_LAT);
  localparam logic [CNT_W-1:0] DEC_LAT_C = CNT_W'(DEC_LAT);
  localparam logic [CNT_W-1:0] KEY_LAT_C = CNT_W'(KEY_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              dir_q, dir_d;
  logic              ready_q, ready_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;
  logic [DATA_W-1:0] core_q, core_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic [CNT_W-1:0]  lat_sel;

`ifdef SERPENT_CBC_EN
  logic [DATA_W-1:0] chain_q, chain_d;
  logic [DATA_W-1:0] ct_q, ct_d;
  logic [DATA_W-1:0] chain_eff;
  logic              iv_take;

  // An IV loaded in the same cycle as an accepted block must already apply to it.
  assign iv_take   = (state_q == S_IDLE) && i_iv_load;
  assign chain_eff = iv_take ? i_iv : chain_q;
`else
  logic unused_iv;
  assign unused_iv = ^{i_iv_load, i_iv};
`endif

  // Only the direction latched at accept decides latency and result source.
  assign lat_sel = dir_q ? ENC_LAT_C : DEC_LAT_C;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    ready_d   = ready_q;
    valid_d   = 1'b0;
    core_d    = core_q;
    out_d     = out_q;
    // A start pulse is dropped when not idle, or when a key load wins the same cycle.
    overrun_d = i_new_block && ((state_q != S_IDLE) || i_key_load);
`ifdef SERPENT_CBC_EN
    chain_d   = iv_take ? i_iv : chain_q;
    ct_d      = ct_q;
`endif

    if (i_key_load) begin
      state_d = S_KEY_WAIT;
      cnt_d   = CNT_ONE;
      ready_d = 1'b0;
    end else begin
      unique case (state_q)
        S_KEY_WAIT: begin
          if (cnt_q == KEY_LAT_C) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            ready_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_IDLE: begin
          if (i_new_block) begin
            state_d = S_BUSY;
            cnt_d   = CNT_ONE;
            ready_d = 1'b0;
            dir_d   = i_dir;
`ifdef SERPENT_CBC_EN
            if (i_dir) begin
              core_d = i_data ^ chain_eff;
            end else begin
              core_d = i_data;
              ct_d   = i_data;
            end
`else
            core_d  = i_data;
`endif
          end
        end
        S_BUSY: begin
          if (cnt_q == lat_sel) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            ready_d = 1'b1;
            valid_d = 1'b1;
`ifdef SERPENT_CBC_EN
            if (dir_q) begin
              out_d   = i_enc_data;
              chain_d = i_enc_data;
            end else begin
              out_d   = i_dec_data ^ chain_q;
              chain_d = ct_q;
            end
`else
            out_d   = dir_q ? i_enc_data : i_dec_data;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = S_KEY_WAIT;
          cnt_d   = '0;
          ready_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_q   <= S_KEY_WAIT;
      cnt_q     <= '0;
      dir_q     <= 1'b0;
      ready_q   <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      core_q    <= '0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      core_q    <= core_d;
      out_q     <= out_d;
    end
  end

`ifdef SERPENT_CBC_EN
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      chain_q <= '0;
      ct_q    <= '0;
    end else begin
      chain_q <= chain_d;
      ct_q    <= ct_d;
    end
  end
`endif

  assign o_core_data = core_q;
  assign o_ready     = ready_q;
  assign o_valid     = valid_q;
  assign o_output    = out_q;
  assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_serpent_stream_ctrl.sv
// tb/tb_serpent_stream_ctrl.sv - self-checking bench for serpent_stream_ctrl
module tb_serpent_stream_ctrl;

  localparam int DATA_W  = 128;
  localparam int ENC_LAT = 32;
  localparam int DEC_LAT = 64;
  localparam int KEY_LAT = 33;
  localparam int CNT_W   = 7;

`ifdef SERPENT_CBC_EN
  localparam logic [DATA_W-1:0] ENC_ADD = '0;
  localparam logic [DATA_W-1:0] DEC_XOR = '0;
`else
  localparam logic [DATA_W-1:0] ENC_ADD = 128'hA5;
  localparam logic [DATA_W-1:0] DEC_XOR = 128'h3C;
`endif

  logic              clk = 1'b0;
  logic              i_resetn;
  logic              i_dir;
  logic              i_key_load;
  logic              i_new_block;
  logic [DATA_W-1:0] i_data;
  logic              i_iv_load;
  logic [DATA_W-1:0] i_iv;
  logic [DATA_W-1:0] o_core_data;
  logic [DATA_W-1:0] i_enc_data;
  logic [DATA_W-1:0] i_dec_data;
  logic              o_ready;
  logic              o_valid;
  logic [DATA_W-1:0] o_output;
  logic              o_overrun;

  always #5 clk = ~clk;

  serpent_stream_ctrl #(
    .DATA_W (DATA_W),
    .ENC_LAT(ENC_LAT),
    .DEC_LAT(DEC_LAT),
    .KEY_LAT(KEY_LAT),
    .CNT_W  (CNT_W)
  ) dut (
    .i_clk      (clk),
    .i_resetn   (i_resetn),
    .i_dir      (i_dir),
    .i_key_load (i_key_load),
    .i_new_block(i_new_block),
    .i_data     (i_data),
    .i_iv_load  (i_iv_load),
    .i_iv       (i_iv),
    .o_core_data(o_core_data),
    .i_enc_data (i_enc_data),
    .i_dec_data (i_dec_data),
    .o_ready    (o_ready),
    .o_valid    (o_valid),
    .o_output   (o_output),
    .o_overrun  (o_overrun)
  );

  // Fixed-latency core models: the result of a block loaded at edge E0 is
  // present on the core output during the cycle ending at edge E0+LAT.
  logic [DATA_W-1:0] enc_pipe [ENC_LAT-1];
  logic [DATA_W-1:0] dec_pipe [DEC_LAT-1];

  always @(posedge clk) begin
    enc_pipe[0] <= o_core_data;
    for (int i = 1; i < ENC_LAT-1; i++) enc_pipe[i] <= enc_pipe[i-1];
    dec_pipe[0] <= o_core_data;
    for (int j = 1; j < DEC_LAT-1; j++) dec_pipe[j] <= dec_pipe[j-1];
  end

  assign i_enc_data = enc_pipe[ENC_LAT-2] + ENC_ADD;
  assign i_dec_data = dec_pipe[DEC_LAT-2] ^ DEC_XOR;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic              iv_load;
    logic [DATA_W-1:0] iv;
    logic              dir;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] exp;
    int                lat;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input logic ivl, input logic [DATA_W-1:0] iv, input logic dir,
                         input logic [DATA_W-1:0] data, input logic [DATA_W-1:0] exp);
    vec_t v;
    v.iv_load = ivl;
    v.iv      = iv;
    v.dir     = dir;
    v.data    = data;
    v.exp     = exp;
    v.lat     = dir ? ENC_LAT : DEC_LAT;
    vq.push_back(v);
  endtask

  task automatic check(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge with o_ready=1; returns at the negedge after the accept edge.
  // i_dir is flipped during BUSY to show only the latched direction matters.
  task automatic issue(input logic dir, input logic [DATA_W-1:0] data,
                       input logic ivl, input logic [DATA_W-1:0] iv);
    i_dir       = dir;
    i_data      = data;
    i_iv_load   = ivl;
    i_iv        = iv;
    i_new_block = 1'b1;
    tick;
    i_new_block = 1'b0;
    i_iv_load   = 1'b0;
    i_dir       = ~dir;
  endtask

  // Edges until o_valid is seen (0 = not seen within max).
  task automatic wait_valid(input int max, output int got);
    got = 0;
    for (int n = 1; n <= max && got == 0; n++) begin
      tick;
      if (o_valid) got = n;
    end
  endtask

  // Edges until o_ready is seen, counting stray valid/overrun pulses on the way.
  task automatic wait_ready(input int max, output int got, output int nval, output int novr);
    got  = 0;
    nval = 0;
    novr = 0;
    for (int n = 1; n <= max && got == 0; n++) begin
      tick;
      if (o_valid)   nval++;
      if (o_overrun) novr++;
      if (o_ready)   got = n;
    end
  endtask

  int got, nval, novr;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    i_resetn    = 1'b0;
    i_dir       = 1'b0;
    i_key_load  = 1'b0;
    i_new_block = 1'b0;
    i_data      = '0;
    i_iv_load   = 1'b0;
    i_iv        = '0;

`ifdef SERPENT_CBC_EN
    add_vec(1'b1, 128'hFF, 1'b1, 128'h0F, 128'hF0);
    add_vec(1'b0, 128'h00, 1'b1, 128'h0F, 128'hFF);
    add_vec(1'b1, 128'hFF, 1'b0, 128'hF0, 128'h0F);
    add_vec(1'b0, 128'h00, 1'b0, 128'hFF, 128'h0F);
`else
    add_vec(1'b0, '0, 1'b1, 128'h1,    128'hA6);
    add_vec(1'b0, '0, 1'b0, 128'h5,    128'h39);
    add_vec(1'b0, '0, 1'b1, {DATA_W{1'b1}}, 128'hA4);
    add_vec(1'b0, '0, 1'b0, 128'h0,    128'h3C);
    add_vec(1'b0, '0, 1'b1, 128'h1234, 128'h12D9);
`endif

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_ready",   o_ready,     0);
    check("rst_valid",   o_valid,     0);
    check("rst_overrun", o_overrun,   0);
    check("rst_output",  o_output,    0);
    check("rst_core",    o_core_data, 0);

    // Key settle after release: the first edge plays the role of the key-load
    // edge (counter 0 -> 1), so o_ready rises KEY_LAT edges after that one.
    i_resetn = 1'b1;
    wait_ready(80, got, nval, novr);
    check("settle_edges",   got,  KEY_LAT + 1);
    check("settle_valid",   nval, 0);
    check("settle_overrun", novr, 0);

    // Table of blocks, each issued in the o_valid cycle of the previous one.
    for (int k = 0; k < vq.size(); k++) begin
      issue(vq[k].dir, vq[k].data, vq[k].iv_load, vq[k].iv);
      check($sformatf("v%0d_ready_fall", k), o_ready, 0);
      check($sformatf("v%0d_valid_low", k),  o_valid, 0);
      wait_valid(DEC_LAT + 8, got);
      check($sformatf("v%0d_latency", k), got, vq[k].lat);
      check($sformatf("v%0d_output", k),  o_output, vq[k].exp);
      check($sformatf("v%0d_ready", k),   o_ready, 1);
    end
    tick;
    check("valid_one_cycle", o_valid, 0);

`ifndef SERPENT_CBC_EN
    // Overrun: extra start pulse at E10 of a busy encrypt.
    issue(1'b1, 128'h7, 1'b0, '0);
    repeat (9) tick;
    i_new_block = 1'b1;
    i_data      = 128'hDEAD;
    tick;
    i_new_block = 1'b0;
    check("ovr_pulse", o_overrun, 1);
    check("ovr_ready", o_ready,   0);
    tick;
    check("ovr_clear", o_overrun, 0);
    wait_valid(40, got);
    check("ovr_latency", got + 11, ENC_LAT);
    check("ovr_output",  o_output, 128'hAC);
    wait_ready(40, got, nval, novr);
    nval = 0;
    for (int n = 0; n < 40; n++) begin
      tick;
      if (o_valid) nval++;
    end
    check("ovr_no_second", nval, 0);

    // Key load at E20 of a busy encrypt aborts the block.
    issue(1'b1, 128'h9, 1'b0, '0);
    repeat (19) tick;
    i_key_load = 1'b1;
    tick;
    i_key_load = 1'b0;
    check("abort_ready", o_ready, 0);
    wait_ready(80, got, nval, novr);
    check("abort_settle", got,      KEY_LAT);
    check("abort_valid",  nval,     0);
    check("abort_output", o_output, 128'hAC);

    // Key load and start together in IDLE: key wins, block dropped.
    i_key_load  = 1'b1;
    i_new_block = 1'b1;
    i_dir       = 1'b1;
    i_data      = 128'h55;
    tick;
    i_key_load  = 1'b0;
    i_new_block = 1'b0;
    check("both_overrun", o_overrun, 1);
    check("both_ready",   o_ready,   0);
    wait_ready(80, got, nval, novr);
    check("both_settle", got,      KEY_LAT);
    check("both_valid",  nval,     0);
    check("both_output", o_output, 128'hAC);

    issue(1'b1, 128'h1, 1'b0, '0);
    wait_valid(40, got);
    check("post_key_latency", got,      ENC_LAT);
    check("post_key_output",  o_output, 128'hA6);
    tick;
`endif

    // Reset asserted mid-block clears everything at once.
    issue(1'b1, 128'h2, 1'b0, '0);
    repeat (5) tick;
    #2 i_resetn = 1'b0;
    #1;
    check("midrst_ready",  o_ready,     0);
    check("midrst_valid",  o_valid,     0);
    check("midrst_output", o_output,    0);
    check("midrst_core",   o_core_data, 0);
    @(negedge clk);
    i_resetn = 1'b1;
    wait_ready(80, got, nval, novr);
    check("midrst_settle", got,  KEY_LAT + 1);
    check("midrst_nvalid", nval, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serpent_stream_ctrl.md
Name: serpent_stream_ctrl

Overview:
- Parametrised successor to the single-block Serpent top-level sequencer.
- Accepts 128-bit blocks with a ready/valid-style handshake and drives a registered block into the external fixed-latency encryption/decryption datapath.
- Captures the result at a per-direction latency and presents it with a one-cycle valid pulse.
- Adds key-schedule settle tracking, abort on key change, overrun reporting, and optional CBC chaining.

Parameters:
- DATA_W, 128, block width in bits.
- ENC_LAT, 32, cycles from core-input register load to valid encryption-core output.
- DEC_LAT, 64, cycles from core-input register load to valid decryption-core output.
- KEY_LAT, 33, cycles the key schedule needs after a key change before blocks may be issued.
- CNT_W, 7, latency counter width; must satisfy 2^CNT_W > max(ENC_LAT, DEC_LAT, KEY_LAT).

Ports:
- i_clk  in  1  clock
- i_resetn  in  1  asynchronous active-low reset
- i_dir  in  1  1 = encrypt, 0 = decrypt; sampled only with accepted i_new_block
- i_key_load  in  1  one-cycle pulse: i_key changed, restart key settle
- i_new_block  in  1  one-cycle start pulse; accepted only when o_ready=1
- i_data  in  DATA_W  input block, sampled with accepted i_new_block
- i_iv_load  in  1  one-cycle pulse: load chaining register from i_iv (CBC build only)
- i_iv  in  DATA_W  initialisation vector
- o_core_data  out  DATA_W  registered block fed to both cipher cores
- i_enc_data  in  DATA_W  encryption core result
- i_dec_data  in  DATA_W  decryption core result
- o_ready  out  1  1 = idle and accepting a block
- o_valid  out  1  one-cycle pulse: o_output holds a new result
- o_output  out  DATA_W  registered result, held until the next capture
- o_overrun  out  1  one-cycle pulse: i_new_block arrived while o_ready=0

Behaviour:
- Reset values:
  - o_ready=0, o_valid=0, o_overrun=0.
  - o_output=0, o_core_data=0, chain=0, counter=0.
  - State=KEY_WAIT.
- States:
  - KEY_WAIT: counter runs 1..KEY_LAT. When counter==KEY_LAT, go to IDLE and set o_ready=1 at that edge.
  - IDLE: o_ready=1. Accepted i_new_block latches dir_q=i_dir and loads o_core_data, sets counter=1, goes to BUSY, and clears o_ready at the same edge.
  - BUSY: counter increments. When counter==LAT(dir_q):
    - o_output is captured from i_enc_data or i_dec_data per dir_q.
    - o_valid=1 for exactly one cycle.
    - o_ready=1 at that same edge; state returns to IDLE.
- Latency: o_valid is high in the cycle after the edge that is LAT edges after the accepting edge. The next block may be accepted in the same cycle o_valid is high.
- Direction: i_dir changes during BUSY have no effect; only dir_q selects latency and source.
- i_key_load:
  - From any state, go to KEY_WAIT with counter=1 and o_ready=0.
  - A block in flight is aborted: no o_valid; o_output keeps its old value.
  - i_key_load during KEY_WAIT restarts the count.
- Simultaneous i_key_load and i_new_block in IDLE: key load wins, block dropped, o_overrun=1.
- i_new_block while o_ready=0 is ignored and o_overrun pulses one cycle.
- Counter:
  - Width CNT_W, never wraps (terminal values are reached before overflow).
  - Holds at 0 in IDLE.
- Reset asserted mid-operation: all state returns to reset values immediately; KEY_LAT settle restarts after release.

Optional Feature:
- Macro SERPENT_CBC_EN.
- Defined (CBC):
  - A DATA_W chain register is added.
  - i_iv_load in IDLE loads chain=i_iv. i_iv_load outside IDLE is ignored. i_iv_load together with an accepted i_new_block loads the IV first, and that block uses the new IV.
  - Encrypt: o_core_data = i_data ^ chain. On capture, o_output = i_enc_data and chain = i_enc_data.
  - Decrypt: o_core_data = i_data; the ciphertext is latched. On capture, o_output = i_dec_data ^ chain and chain = latched ciphertext.
  - An aborted block leaves chain unchanged.
- Undefined (ECB): i_iv and i_iv_load are unused; o_core_data = i_data; o_output = raw core result.

Test Plan:
- Reset released at t0 -> o_ready=0 for 33 cycles, then o_ready=1; o_valid and o_overrun stay 0.
- Encrypt, i_data=0x1 accepted at edge E0, core model returns data+0xA5 delayed 32 cycles -> o_valid high only in the cycle after E32, o_output=0xA6, o_ready=1 from E32.
- Decrypt, i_data=0x5 -> o_valid after E64 with the i_dec_data value; back-to-back block issued in the o_valid cycle is accepted (o_ready falls next edge).
- i_new_block pulsed at E10 of a busy encrypt -> o_overrun one cycle; original result still valid after E32; no second result.
- i_key_load at E20 of a busy encrypt -> no o_valid, o_output unchanged, o_ready returns 33 cycles later.
- SERPENT_CBC_EN, i_iv=0xFF, identity core, encrypt 0x0F then 0x0F -> o_output 0xF0 then 0xFF; decrypt of 0xF0 then 0xFF with i_iv=0xFF -> outputs 0x0F, 0x0F.
